// File: rtl/nfc_frame_sequencer.sv
// Command-frame sequencer feeding a single-byte I2C master; optional ready polling under NFC_SEQ_READY_POLL_EN.
// Latency: first write request the cycle after the last command beat; response byte visible one cycle after i2c_done rises.
// Backpressure: cmd_ready low while a frame is in flight; reads stall (no i2c_start) while the response FIFO is full.

module nfc_seq_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head reads zero when empty so the output is defined straight out of reset.
    assign head    = empty ? '0 : mem[rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= push_dat;
    end
endmodule

module nfc_frame_sequencer #(
    parameter logic [6:0] SLAVE_ADDR = 7'h24,
    parameter int         MAX_LEN    = 16,
    parameter int         RX_DEPTH   = 16,
    parameter int         POLL_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_last,
    input  logic [7:0] rsp_len,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_byte,
    output logic       rsp_last,
    output logic       i2c_start,
    output logic       i2c_rw,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_tx,
    input  logic [7:0] i2c_rx,
    input  logic       i2c_busy,
    input  logic       i2c_done,
    output logic       seq_busy,
    output logic       err_timeout
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;

    if (MAX_LEN < 2 || (MAX_LEN & (MAX_LEN - 1)) != 0) begin : g_bad_max_len
        $error("MAX_LEN must be a power of 2 and at least 2");
    end
    if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
        $error("RX_DEPTH must be a power of 2 and at least 2");
    end
    if (POLL_LIMIT < 1 || POLL_LIMIT > 255) begin : g_bad_poll_limit
        $error("POLL_LIMIT must be within 1..255");
    end

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        WR_ISSUE   = 3'd2,
        WR_WAIT    = 3'd3,
`ifdef NFC_SEQ_READY_POLL_EN
        POLL_ISSUE = 3'd4,
        POLL_WAIT  = 3'd5,
`endif
        RD_ISSUE   = 3'd6,
        RD_WAIT    = 3'd7
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    cmd_buf [MAX_LEN];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] tx_idx;
    logic [IW-1:0] tx_idx_nxt;
    logic [LW-1:0] frame_len;
    logic [7:0]    rsp_len_q;
    logic [7:0]    rd_cnt;
    logic          done_q;

    logic          cmd_beat;
    logic          frame_end;
    logic          done_rise;
    logic          tx_last;
    logic          rd_last;
    logic          start_nxt;
    logic          rw_nxt;
    logic [7:0]    tx_nxt;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;

`ifdef NFC_SEQ_READY_POLL_EN
    logic [7:0]    poll_cnt;
    logic          timeout_set;
`endif

    assign i2c_addr  = SLAVE_ADDR;
    assign cmd_beat  = cmd_valid & cmd_ready;
    assign frame_end = cmd_beat & (cmd_last | (wr_idx == IW'(MAX_LEN - 1)));
    assign done_rise = i2c_done & ~done_q;
    assign tx_last   = ({1'b0, tx_idx} == (frame_len - LW'(1)));
    assign rd_last   = (rd_cnt == (rsp_len_q - 8'd1));
    assign rsp_valid = ~fifo_empty;

    always_comb begin
        state_nxt  = state;
        start_nxt  = 1'b0;
        rw_nxt     = i2c_rw;
        tx_nxt     = i2c_tx;
        tx_idx_nxt = tx_idx;
        push       = 1'b0;
`ifdef NFC_SEQ_READY_POLL_EN
        timeout_set = 1'b0;
`endif
        case (state)
            IDLE:     if (cmd_beat) state_nxt = frame_end ? WR_ISSUE : LOAD;
            LOAD:     if (frame_end) state_nxt = WR_ISSUE;
            WR_ISSUE: if (i2c_start && i2c_busy) state_nxt = WR_WAIT;
            WR_WAIT: begin
                if (done_rise) begin
`ifdef NFC_SEQ_READY_POLL_EN
                    state_nxt = tx_last ? POLL_ISSUE : WR_ISSUE;
`else
                    if (!tx_last)              state_nxt = WR_ISSUE;
                    else if (rsp_len_q == 8'd0) state_nxt = IDLE;
                    else                        state_nxt = RD_ISSUE;
`endif
                end
            end
`ifdef NFC_SEQ_READY_POLL_EN
            POLL_ISSUE: if (i2c_start && i2c_busy) state_nxt = POLL_WAIT;
            POLL_WAIT: begin
                if (done_rise) begin
                    if (i2c_rx[0]) begin
                        state_nxt = (rsp_len_q == 8'd0) ? IDLE : RD_ISSUE;
                    end else if ((poll_cnt + 8'd1) == 8'(POLL_LIMIT)) begin
                        timeout_set = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        state_nxt = POLL_ISSUE;
                    end
                end
            end
`endif
            RD_ISSUE: if (i2c_start && i2c_busy) state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (done_rise) begin
                    push      = 1'b1;
                    state_nxt = rd_last ? IDLE : RD_ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state == WR_WAIT && done_rise) tx_idx_nxt = tx_idx + IW'(1);
        if (state_nxt == IDLE)             tx_idx_nxt = '0;

        case (state_nxt)
            WR_ISSUE: begin
                start_nxt = 1'b1;
                rw_nxt    = 1'b0;
                // A one-byte frame ends on the beat that writes buf[0], so bypass the buffer.
                tx_nxt    = (cmd_beat && wr_idx == tx_idx_nxt) ? cmd_byte : cmd_buf[tx_idx_nxt];
            end
`ifdef NFC_SEQ_READY_POLL_EN
            POLL_ISSUE: begin
                start_nxt = 1'b1;
                rw_nxt    = 1'b1;
            end
`endif
            RD_ISSUE: begin
                // Wait one cycle after entry so the FIFO count reflects the last push.
                start_nxt = (state == RD_ISSUE) && (i2c_start || !fifo_full);
                rw_nxt    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_idx    <= '0;
            tx_idx    <= '0;
            frame_len <= '0;
            rsp_len_q <= '0;
            rd_cnt    <= '0;
            done_q    <= 1'b0;
            i2c_start <= 1'b0;
            i2c_rw    <= 1'b0;
            i2c_tx    <= '0;
            cmd_ready <= 1'b1;
            seq_busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_q    <= i2c_done;
            i2c_start <= start_nxt;
            i2c_rw    <= rw_nxt;
            i2c_tx    <= tx_nxt;
            tx_idx    <= tx_idx_nxt;
            cmd_ready <= (state_nxt == IDLE) || (state_nxt == LOAD);
            seq_busy  <= (state_nxt != IDLE) && (state_nxt != LOAD);
            if (cmd_beat) wr_idx <= wr_idx + IW'(1);
            if (frame_end) begin
                frame_len <= LW'(wr_idx) + LW'(1);
                rsp_len_q <= rsp_len;
            end
            if (push) rd_cnt <= rd_cnt + 8'd1;
            if (state_nxt == IDLE) begin
                wr_idx <= '0;
                rd_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_beat) cmd_buf[wr_idx] <= cmd_byte;
    end

`ifdef NFC_SEQ_READY_POLL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == POLL_WAIT && done_rise && !i2c_rx[0]) poll_cnt <= poll_cnt + 8'd1;
            if (state_nxt == IDLE) poll_cnt <= '0;
            if (timeout_set)       err_timeout <= 1'b1;
            else if (cmd_beat)     err_timeout <= 1'b0;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    nfc_seq_fifo #(
        .W     (9),
        .DEPTH (RX_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({rd_last, i2c_rx}),
        .pop      (rsp_ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     ({rsp_last, rsp_byte})
    );
endmodule

// File: tb/tb_nfc_frame_sequencer.sv
// Directed bench for nfc_frame_sequencer with a behavioural single-byte I2C master and response collector.
module tb_nfc_frame_sequencer;
`ifdef NFC_SEQ_READY_POLL_EN
    localparam int NPOLL = 1;
`else
    localparam int NPOLL = 0;
`endif

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_last;
    logic [7:0] rsp_len;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_byte;
    logic       rsp_last;
    logic       i2c_start;
    logic       i2c_rw;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_tx;
    logic [7:0] i2c_rx;
    logic       i2c_busy;
    logic       i2c_done;
    logic       seq_busy;
    logic       err_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] frm [16];
    logic [7:0] rd_q [$];
    logic       log_rw [$];
    logic [7:0] log_tx [$];
    logic [8:0] rcv [$];

    nfc_frame_sequencer #(
        .SLAVE_ADDR (7'h24),
        .MAX_LEN    (16),
        .RX_DEPTH   (2),
        .POLL_LIMIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_byte    (cmd_byte),
        .cmd_last    (cmd_last),
        .rsp_len     (rsp_len),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_byte    (rsp_byte),
        .rsp_last    (rsp_last),
        .i2c_start   (i2c_start),
        .i2c_rw      (i2c_rw),
        .i2c_addr    (i2c_addr),
        .i2c_tx      (i2c_tx),
        .i2c_rx      (i2c_rx),
        .i2c_busy    (i2c_busy),
        .i2c_done    (i2c_done),
        .seq_busy    (seq_busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I2C master: busy one cycle after start, done held high for two cycles.
    initial begin
        i2c_busy = 1'b0;
        i2c_done = 1'b0;
        i2c_rx   = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (i2c_start && !i2c_busy) begin
                log_rw.push_back(i2c_rw);
                log_tx.push_back(i2c_tx);
                i2c_busy = 1'b1;
                repeat (2) begin @(posedge clk); #1; end
                if (i2c_rw) i2c_rx = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                i2c_done = 1'b1;
                i2c_busy = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                i2c_done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk); #1;
            if (rsp_valid && rsp_ready) rcv.push_back({rsp_last, rsp_byte});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_rw(input logic rw);
        int c = 0;
        foreach (log_rw[i]) if (log_rw[i] == rw) c++;
        return c;
    endfunction

    task automatic clear_logs();
        log_rw.delete();
        log_tx.delete();
        rcv.delete();
        rd_q.delete();
        if (NPOLL == 1) rd_q.push_back(8'h01);
    endtask

    task automatic send_frame(input int n, input logic [7:0] rl, input bit use_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_byte  = frm[i];
            cmd_last  = use_last && (i == n - 1);
            rsp_len   = rl;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        chk("cmd_ready_drop", cmd_ready, 1'b0);
        chk("first_wr_start", i2c_start, 1'b1);
        chk("first_wr_rw", i2c_rw, 1'b0);
        chk("first_wr_tx", i2c_tx, frm[0]);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 3000 && seq_busy; k++) @(negedge clk);
        chk(tag, seq_busy, 1'b0);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int n);
        int bad = 0;
        chk({tag, "_nwr"}, count_rw(1'b0), n);
        for (int i = 0; i < n && i < log_tx.size(); i++)
            if (log_rw[i] !== 1'b0 || log_tx[i] !== frm[i]) bad++;
        chk({tag, "_wr_bytes"}, bad, 0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        cmd_last  = 1'b0;
        rsp_len   = 8'h00;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_byte", rsp_byte, 8'h00);
        chk("rst_rsp_last", rsp_last, 1'b0);
        chk("rst_i2c_start", i2c_start, 1'b0);
        chk("rst_i2c_rw", i2c_rw, 1'b0);
        chk("rst_i2c_tx", i2c_tx, 8'h00);
        chk("rst_seq_busy", seq_busy, 1'b0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        chk("i2c_addr", i2c_addr, 7'h24);
        reset = 1'b0;
        @(negedge clk);

        // Frame {D4,02}, three response bytes.
        clear_logs();
        rd_q.push_back(8'hAA); rd_q.push_back(8'hBB); rd_q.push_back(8'hCC);
        frm[0] = 8'hD4; frm[1] = 8'h02;
        send_frame(2, 8'd3, 1'b1);
        chk("f1_busy", seq_busy, 1'b1);
        wait_idle("f1_idle");
        check_writes("f1", 2);
        chk("f1_nrd", count_rw(1'b1), NPOLL + 3);
        chk("f1_nrcv", rcv.size(), 3);
        if (rcv.size() == 3) begin
            chk("f1_rsp0", rcv[0], {1'b0, 8'hAA});
            chk("f1_rsp1", rcv[1], {1'b0, 8'hBB});
            chk("f1_rsp2", rcv[2], {1'b1, 8'hCC});
        end
        chk("f1_err", err_timeout, 1'b0);

`ifdef NFC_SEQ_READY_POLL_EN
        // Reader never ready: four polls then timeout.
        clear_logs();
        rd_q.delete();
        for (int i = 0; i < 8; i++) rd_q.push_back(8'h00);
        frm[0] = 8'h4A;
        send_frame(1, 8'd2, 1'b1);
        wait_idle("to_idle");
        chk("to_nwr", count_rw(1'b0), 1);
        chk("to_npoll", count_rw(1'b1), 4);
        chk("to_err_set", err_timeout, 1'b1);
        chk("to_fifo_empty", rsp_valid, 1'b0);
        clear_logs();
        frm[0] = 8'h00;
        send_frame(1, 8'd0, 1'b1);
        chk("to_err_cleared", err_timeout, 1'b0);
        wait_idle("to_clr_idle");
`endif

        // Sixteen beats with no cmd_last: the sixteenth ends the frame.
        clear_logs();
        rd_q.push_back(8'h5A);
        for (int i = 0; i < 16; i++) frm[i] = 8'h10 + 8'(i);
        send_frame(16, 8'd1, 1'b0);
        wait_idle("ml_idle");
        check_writes("ml", 16);
        chk("ml_nrd", count_rw(1'b1), NPOLL + 1);
        chk("ml_nrcv", rcv.size(), 1);
        if (rcv.size() == 1) chk("ml_rsp0", rcv[0], {1'b1, 8'h5A});

        // Response FIFO backpressure with a two-entry FIFO.
        clear_logs();
        for (int i = 1; i <= 5; i++) rd_q.push_back(8'(8'h11 * i));
        rsp_ready = 1'b0;
        frm[0] = 8'h33;
        send_frame(1, 8'd5, 1'b1);
        repeat (80) @(negedge clk);
        chk("bp_nrd_stalled", count_rw(1'b1), NPOLL + 2);
        chk("bp_start_low", i2c_start, 1'b0);
        chk("bp_busy", seq_busy, 1'b1);
        chk("bp_head", {rsp_valid, rsp_last, rsp_byte}, {1'b1, 1'b0, 8'h11});
        rsp_ready = 1'b1;
        wait_idle("bp_idle");
        chk("bp_nrcv", rcv.size(), 5);
        begin
            int bad = 0;
            for (int i = 0; i < rcv.size(); i++)
                if (rcv[i] !== {(i == 4), 8'(8'h11 * (i + 1))}) bad++;
            chk("bp_order", bad, 0);
        end

        // Reset in the middle of the second write of four.
        clear_logs();
        rd_q.push_back(8'h42);
        frm[0] = 8'hA1; frm[1] = 8'hA2; frm[2] = 8'hA3; frm[3] = 8'hA4;
        send_frame(4, 8'd1, 1'b1);
        for (int k = 0; k < 200 && log_tx.size() < 2; k++) @(negedge clk);
        chk("rs_second_write", log_tx.size(), 2);
        reset = 1'b1;
        @(negedge clk);
        chk("rs_start", i2c_start, 1'b0);
        chk("rs_busy", seq_busy, 1'b0);
        chk("rs_rsp_valid", rsp_valid, 1'b0);
        chk("rs_cmd_ready", cmd_ready, 1'b1);
        reset = 1'b0;
        for (int k = 0; k < 50 && (i2c_busy || i2c_done); k++) @(negedge clk);
        chk("rs_master_quiet", {i2c_busy, i2c_done}, 2'b00);
        repeat (2) @(negedge clk);
        clear_logs();
        rd_q.push_back(8'h77);
        frm[0] = 8'h5E;
        send_frame(1, 8'd1, 1'b1);
        wait_idle("rs_idle");
        check_writes("rs", 1);
        chk("rs_nrd", count_rw(1'b1), NPOLL + 1);
        chk("rs_nrcv", rcv.size(), 1);
        if (rcv.size() == 1) chk("rs_rsp0", rcv[0], {1'b1, 8'h77});

        // Single-byte frame, single response byte.
        clear_logs();
        rd_q.push_back(8'h9C);
        frm[0] = 8'h01;
        send_frame(1, 8'd1, 1'b1);
        wait_idle("sb_idle");
        check_writes("sb", 1);
        chk("sb_nrd", count_rw(1'b1), NPOLL + 1);
        chk("sb_nrcv", rcv.size(), 1);
        if (rcv.size() == 1) chk("sb_rsp0", rcv[0], {1'b1, 8'h9C});
        chk("sb_err", err_timeout, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/nfc_frame_sequencer.md
# nfc_frame_sequencer

Command-frame sequencer sitting directly upstream of the I2C byte master in the RFID/NFC reader path. Accepts a multi-byte command frame from the host logic, issues it to the I2C master one single-byte transaction at a time, polls the reader's ready byte, then reads back a fixed-length response into an output FIFO. It owns the I2C master's `start`/`read_write`/`addr`/`tx_data` inputs and consumes its `rx_data`/`busy`/`done` outputs.

## Interface
- `SLAVE_ADDR`, 7'h24, 7-bit reader address driven on `i2c_addr`
- `MAX_LEN`, 16, command buffer depth in bytes (power of 2, ≥2)
- `RX_DEPTH`, 16, response FIFO depth in bytes (power of 2, ≥2)
- `POLL_LIMIT`, 255, max ready-byte polls before timeout (1..255)

- `clk`  in  1  system clock; sole clock
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command byte valid
- `cmd_ready`  out  1  sequencer accepts command byte
- `cmd_byte`  in  8  command byte
- `cmd_last`  in  1  final byte of frame
- `rsp_len`  in  8  response bytes to read; sampled on the `cmd_last` beat
- `rsp_valid`  out  1  response FIFO non-empty
- `rsp_ready`  in  1  consumer pops head byte
- `rsp_byte`  out  8  FIFO head (first-word fall-through)
- `rsp_last`  out  1  head byte is last of response
- `i2c_start`  out  1  transaction request to I2C master
- `i2c_rw`  out  1  0 = write, 1 = read
- `i2c_addr`  out  7  constant `SLAVE_ADDR`
- `i2c_tx`  out  8  byte to write
- `i2c_rx`  in  8  byte read by master
- `i2c_busy`  in  1  master busy
- `i2c_done`  in  1  master transaction complete
- `seq_busy`  out  1  high in any state except IDLE/LOAD
- `err_timeout`  out  1  sticky; set on poll timeout, cleared on next accepted `cmd_valid` beat

## Operation
- States: IDLE, LOAD, WR_ISSUE, WR_WAIT, POLL_ISSUE, POLL_WAIT, RD_ISSUE, RD_WAIT.
- IDLE/LOAD: `cmd_ready`=1. Beat = `cmd_valid & cmd_ready`; byte written at `wr_idx`, `wr_idx`++. IDLE→LOAD on first beat. Beat with `cmd_last`, or the `MAX_LEN`-th beat (forced end), latches `frame_len` and `rsp_len` → WR_ISSUE; `cmd_ready` drops same cycle.
- WR_ISSUE: `i2c_rw`=0, `i2c_tx`=buf[`tx_idx`], `i2c_start`=1; held until `i2c_busy`=1 sampled, then `i2c_start`=0 → WR_WAIT.
- WR_WAIT: on rising edge of `i2c_done` (internal registered edge detect), `tx_idx`++; if `tx_idx`==`frame_len`-1 → POLL_ISSUE (reads: RD_ISSUE when macro absent), else WR_ISSUE.
- POLL_ISSUE: as WR_ISSUE with `i2c_rw`=1.
- POLL_WAIT: on `i2c_done` edge: `i2c_rx[0]`=1 → RD_ISSUE (IDLE if `rsp_len`=0); else `poll_cnt`++; `poll_cnt` reaching `POLL_LIMIT` → set `err_timeout`, IDLE; else POLL_ISSUE.
- RD_ISSUE: stalls (no `i2c_start`) while FIFO full; otherwise issues read like POLL_ISSUE → RD_WAIT.
- RD_WAIT: on `i2c_done` edge push `i2c_rx` into FIFO with last-flag = (`rd_cnt`==`rsp_len`-1); `rd_cnt`++; done → IDLE, else RD_ISSUE.
- Return to IDLE clears `wr_idx`, `tx_idx`, `poll_cnt`, `rd_cnt`; FIFO contents retained.
- FIFO: simultaneous push and pop allowed at any occupancy, count unchanged; pop when empty ignored.

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_byte`=0, `rsp_last`=0, `i2c_start`=0, `i2c_rw`=0, `i2c_tx`=0, `seq_busy`=0, `err_timeout`=0; state IDLE, FIFO empty, all counters 0.
- Reset mid-transaction: all of the above on next edge; `i2c_start` drops immediately; FIFO flushed; in-flight I2C result ignored.
- All outputs registered except `rsp_byte`/`rsp_last`/`rsp_valid` (FIFO head, registered storage).
- Pushed byte visible on `rsp_valid` one cycle after the `i2c_done` edge.
- WR_ISSUE entered the cycle after the terminating command beat.
- `i2c_done` held high across cycles counts once (edge only).

## Configuration
- `NFC_SEQ_READY_POLL_EN` defined: POLL_ISSUE/POLL_WAIT compiled in; timeout logic present.
- Undefined: poll states, `poll_cnt` and timeout logic removed; WR_WAIT goes straight to RD_ISSUE (IDLE if `rsp_len`=0); `err_timeout` tied 0; `POLL_LIMIT` unused.

## Test plan
- Frame {D4,02} with `cmd_last`, `rsp_len`=3, model returns poll 01 then AA,BB,CC -> two writes D4,02 with `i2c_rw`=0, one poll, three reads; FIFO yields AA,BB,CC, `rsp_last` only on CC.
- Model returns ready byte 00 forever, `POLL_LIMIT`=4 -> exactly 4 poll reads, `err_timeout`=1, state IDLE, FIFO empty; next command beat clears flag.
- `MAX_LEN`=16, 16 beats without `cmd_last` -> 16th beat ends frame, `cmd_ready`=0 next cycle, 16 writes issued.
- `RX_DEPTH`=2, `rsp_len`=5, `rsp_ready`=0 -> `i2c_start` stays 0 after 2 reads; raising `rsp_ready` resumes, all 5 bytes delivered in order.
- `reset` pulsed during 2nd write of 4 -> next cycle `i2c_start`=0, `seq_busy`=0, `rsp_valid`=0; subsequent frame completes normally.
- Macro undefined, frame {01}, `rsp_len`=1 -> no poll read; one write then one read; `err_timeout` stays 0.
